keypad_encode: RTL
==================

# keypad_encode

Scanning encoder for a 4x4 membrane keypad. It drives the keypad rows, samples the columns, debounces, and emits a 4-bit key code with a one-cycle valid strobe. It is the input-side counterpart of the segment decoder: `key_o` is directly consumable by the digit register that feeds the 7-segment display path. It sits between the keypad pins and the vending-machine control FSM.

## Interface
- `SCAN_DIV`, 50000: clock cycles per row dwell (one scan tick). Minimum 4.
- `DEBOUNCE_N`, 20: consecutive ticks required to accept a press or a release. Minimum 1.
- `REPEAT_N`, 500: ticks between auto-repeat strobes. Used only with `KEYPAD_REPEAT_EN`.
- `clk_i`, input, 1: system clock.
- `n_rst_i`, input, 1: asynchronous, active-low reset.
- `col_i`, input, 4: keypad columns. Pulled up; low means a key is closed. Asynchronous to `clk_i`.
- `row_o`, output, 4: row drive, active low, exactly one bit low at all times.
- `key_o`, output, 4: code of the last accepted key.
- `key_vld_o`, output, 1: one-cycle pulse per accepted press (and per repeat).
- `key_hold_o`, output, 1: high while the accepted key is held.

## Operation
- `col_i` passes through a 2-flop synchroniser. All sampling uses the synchronised value.
- Tick divider counts 0..SCAN_DIV-1 and raises `tick` when the count is SCAN_DIV-1. It free-runs in every state.
- Key code map (row r, column c), with r = index of the low bit of `row_o`:
  - row0: 1, 2, 3, 10
  - row1: 4, 5, 6, 11
  - row2: 7, 8, 9, 12
  - row3: 14, 0, 15, 13
- FSM states: SCAN, DEBOUNCE, PRESSED, RELEASE.
- **SCAN:**
  - On tick, if any synchronised column is low, capture the candidate (current row, lowest-index low column), clear `cnt`, and go to DEBOUNCE. `row_o` does not advance.
  - Otherwise, rotate `row_o` to the next row (row3 wraps to row0).
- **DEBOUNCE:**
  - `row_o` is frozen on the candidate row.
  - On tick, if the candidate column is low, increment `cnt`. When `cnt` reaches DEBOUNCE_N, latch `key_o`, pulse `key_vld_o`, set `key_hold_o`, and go to PRESSED.
  - If the candidate column is high on a tick, return to SCAN and advance the row. `key_o` is unchanged.
- **PRESSED:**
  - On tick, if the candidate column is high, clear `cnt` and go to RELEASE.
- **RELEASE:**
  - On tick, if the candidate column is high, increment `cnt`. When `cnt` reaches DEBOUNCE_N, clear `key_hold_o`, advance the row, and go to SCAN.
  - If the candidate column is low on a tick, return to PRESSED with no new strobe (bounce on release).
- Multiple keys:
  - Only the candidate key is tracked. Other keys are ignored until the candidate is released.
  - Several columns low in one row: the lowest index wins.
- `key_o` holds its last value indefinitely. It is never cleared except by reset.

## Timing
- Reset values: `row_o`=4'b1110, `key_o`=4'd0, `key_vld_o`=0, `key_hold_o`=0, state=SCAN, divider=0, `cnt`=0. Synchroniser flops reset to 4'b1111.
- Reset asserted mid-operation returns immediately (asynchronously) to these values. No strobe is emitted on reset exit.
- Row dwell is SCAN_DIV cycles. A column change must precede a tick by at least 2 cycles to be seen on that tick.
- `key_vld_o` and `key_hold_o` are registered. They rise 1 cycle after the tick on which `cnt` reaches DEBOUNCE_N.
- Press latency: DEBOUNCE_N*SCAN_DIV + 1 cycles from the capture tick.
- `key_vld_o` is never high for 2 consecutive cycles.
- `key_hold_o` falls 1 cycle after the release-qualifying tick.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - In PRESSED, a repeat counter counts ticks while the key stays low.
  - Every REPEAT_N ticks it pulses `key_vld_o` again with the same `key_o`.
  - The counter clears on entry to PRESSED.
  - A transition PRESSED→RELEASE→PRESSED (release bounce) restarts the repeat count.
- `KEYPAD_REPEAT_EN` undefined:
  - Exactly one strobe per press.
  - The repeat counter and `REPEAT_N` logic are absent.

## Structure
- Shared package `keypad_pkg` holds:
  - the FSM state enum,
  - the 16-entry key-code lookup constant,
  - the row reset constant 4'b1110.
- One sub-module, `scan_tick`: parameterised divider producing the single-cycle `tick`. It is reused by the display multiplexer.
- Synchroniser, FSM, and counters stay in `keypad_encode`.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_N=3, REPEAT_N=5.
- Reset with no keys pressed:
  - `row_o` cycles 1110→1101→1011→0111→1110, advancing every 4 cycles.
  - `key_vld_o` stays 0.
  - `key_o`=0.
- Hold row2/col1 steady:
  - `row_o` freezes at 1011.
  - One `key_vld_o` pulse arrives 13 cycles after the capture tick, with `key_o`=8 and `key_hold_o`=1.
  - After release plus 3 high ticks, `key_hold_o`=0 and scanning resumes.
- Press row0/col3 for 2 ticks only:
  - No strobe.
  - FSM returns to SCAN.
  - `key_o` keeps its previous value.
- Hold row3/col0 and row3/col2 together:
  - `key_o`=14 (lowest column wins).
  - Exactly one strobe.
- Assert `n_rst_i` low during DEBOUNCE, then release reset:
  - All outputs return to reset values immediately.
  - No strobe is emitted.
- With `KEYPAD_REPEAT_EN`, hold row1/col2 for 20 ticks after acceptance:
  - Initial strobe plus 4 repeat strobes, spaced 20 cycles apart.
  - `key_o`=6 throughout.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: scan FSM states, key-code map and row helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } keypad_state_e;

  localparam logic [3:0] ROW_RST = 4'b1110;

  // Indexed by {row, column}.
  localparam logic [3:0] KEY_LUT [16] = '{
    4'd1,  4'd2, 4'd3,  4'd10,
    4'd4,  4'd5, 4'd6,  4'd11,
    4'd7,  4'd8, 4'd9,  4'd12,
    4'd14, 4'd0, 4'd15, 4'd13
  };

  // Index of the lowest-numbered low bit; also recovers the row index from row_o.
  function automatic logic [1:0] first_low(input logic [3:0] v);
    if (!v[0]) return 2'd0;
    if (!v[1]) return 2'd1;
    if (!v[2]) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    return KEY_LUT[{r, c}];
  endfunction

endpackage

// File: rtl/keypad_encode_scan_tick.sv
// scan_tick: free-running divider emitting a one-cycle tick every DIV clocks.
module scan_tick #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic n_rst_i,
  output logic tick_o
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] div_q;

  assign tick_o = (div_q == LAST);

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i)    div_q <= '0;
    else if (tick_o) div_q <= '0;
    else             div_q <= div_q + 1'b1;
  end
endmodule

// File: rtl/keypad_encode.sv
// 4x4 keypad scanner: row drive, column synchroniser, debounce FSM, key code + strobe.
// Build option KEYPAD_REPEAT_EN adds auto-repeat strobes while the key stays held.
module keypad_encode
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int DEBOUNCE_N = 20,
  parameter int REPEAT_N   = 500
) (
  input  logic       clk_i,
  input  logic       n_rst_i,
  input  logic [3:0] col_i,
  output logic [3:0] row_o,
  output logic [3:0] key_o,
  output logic       key_vld_o,
  output logic       key_hold_o
);
  localparam int CNT_W = $clog2(DEBOUNCE_N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_N - 1);

  if (SCAN_DIV < 4 || DEBOUNCE_N < 1 || REPEAT_N < 1) begin : g_param_chk
    $error("keypad_encode: SCAN_DIV >= 4, DEBOUNCE_N >= 1, REPEAT_N >= 1 required");
  end

  logic [3:0]    col_p0, col_p1;
  logic          tick;
  keypad_state_e state_q, state_d;
  logic [3:0]    row_q, row_d, row_adv;
  logic [1:0]    cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]    key_q, key_d;
  logic          vld_q, vld_d;
  logic          hold_q, hold_d;
  logic          cand_low;

`ifdef KEYPAD_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_N + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_N - 1);
  logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

  // stage p0/p1: column synchroniser
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      col_p0 <= 4'hF;
      col_p1 <= 4'hF;
    end else begin
      col_p0 <= col_i;
      col_p1 <= col_p0;
    end
  end

  scan_tick #(.DIV(SCAN_DIV)) u_tick (
    .clk_i  (clk_i),
    .n_rst_i(n_rst_i),
    .tick_o (tick)
  );

  assign row_adv  = {row_q[2:0], row_q[3]};
  assign cand_low = ~col_p1[cand_q];

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    vld_d   = 1'b0;
    hold_d  = hold_q;
`ifdef KEYPAD_REPEAT_EN
    rpt_d   = rpt_q;
`endif
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (col_p1 != 4'hF) begin
            cand_d  = first_low(col_p1);
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            row_d = row_adv;
          end
        end
        DEBOUNCE: begin
          if (cand_low) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              key_d   = key_code(first_low(row_q), cand_q);
              vld_d   = 1'b1;
              hold_d  = 1'b1;
              state_d = PRESSED;
`ifdef KEYPAD_REPEAT_EN
              rpt_d   = '0;
`endif
            end
          end else begin
            row_d   = row_adv;
            state_d = SCAN;
          end
        end
        PRESSED: begin
          if (!cand_low) begin
            cnt_d   = '0;
            state_d = RELEASE;
          end
`ifdef KEYPAD_REPEAT_EN
          else if (rpt_q == RPT_LAST) begin
            vld_d = 1'b1;
            rpt_d = '0;
          end else begin
            rpt_d = rpt_q + 1'b1;
          end
`endif
        end
        RELEASE: begin
          if (!cand_low) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              hold_d  = 1'b0;
              row_d   = row_adv;
              state_d = SCAN;
            end
          end else begin
            // release bounce: back to held without a new strobe
            state_d = PRESSED;
`ifdef KEYPAD_REPEAT_EN
            rpt_d   = '0;
`endif
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q <= SCAN;
      row_q   <= ROW_RST;
      cand_q  <= 2'd0;
      cnt_q   <= '0;
      key_q   <= 4'd0;
      vld_q   <= 1'b0;
      hold_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      vld_q   <= vld_d;
      hold_q  <= hold_d;
`ifdef KEYPAD_REPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end

  assign row_o      = row_q;
  assign key_o      = key_q;
  assign key_vld_o  = vld_q;
  assign key_hold_o = hold_q;
endmodule
